// File: rtl/btn_pkg.sv
// Shared types for the button event path: FSM states and the event codes
// that a downstream event encoder/FIFO stage will pack.
package btn_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESS1    = 3'd1,
      LONG_HELD = 3'd2,
      WAIT_GAP  = 3'd3,
      PRESS2    = 3'd4
   } btn_state_t;

   typedef logic [2:0] event_code_t;

   localparam event_code_t EV_NONE    = 3'd0;
   localparam event_code_t EV_PRESS   = 3'd1;
   localparam event_code_t EV_RELEASE = 3'd2;
   localparam event_code_t EV_SHORT   = 3'd3;
   localparam event_code_t EV_LONG    = 3'd4;
   localparam event_code_t EV_DOUBLE  = 3'd5;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_event_fsm_if.sv
// Button level in, classified single-cycle events out.
interface button_event_fsm_if;
   logic clean_in;
   logic press_pulse;
   logic release_pulse;
   logic short_press;
   logic long_press;
   logic double_click;
   logic busy;

   modport master (
      output clean_in,
      input  press_pulse, release_pulse, short_press, long_press, double_click, busy
   );

   modport slave (
      input  clean_in,
      output press_pulse, release_pulse, short_press, long_press, double_click, busy
   );
endinterface

// File: rtl/btn_edge_det.sv
// Rise/fall detector on an already-synchronous level. prev powers up high so a
// button held through reset is not seen as a fresh press.
module btn_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic rise,
   output logic fall
);
   logic prev_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_reg <= 1'b1;
      else        prev_reg <= level;
   end

   assign rise = level & ~prev_reg;
   assign fall = ~level & prev_reg;
endmodule

// File: rtl/button_event_fsm.sv
// Classifies a clean button level into press/release/short/long/double-click
// pulses using one FSM and one shared saturating cycle counter.
module button_event_fsm
   import btn_pkg::*;
#(
   parameter int LONG_CYCLES = 16,
   parameter int GAP_CYCLES  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   button_event_fsm_if.slave  bus
);
   localparam int CNT_W = $clog2(max_int(LONG_CYCLES, GAP_CYCLES)) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYCLES);

   if (LONG_CYCLES < 2) begin : g_bad_long
      $error("button_event_fsm: LONG_CYCLES must be >= 2");
   end
   if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("button_event_fsm: GAP_CYCLES must be >= 1");
   end

   logic rise;
   logic fall;

   btn_edge_det u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .level (bus.clean_in),
      .rise  (rise),
      .fall  (fall)
   );

   btn_state_t       state_reg, state_next;
   logic [CNT_W-1:0] count_reg, count_next, count_inc;
   logic press_reg,   press_next;
   logic release_reg, release_next;
   logic short_reg,   short_next;
   logic long_reg,    long_next;
   logic double_reg,  double_next;
   logic busy_reg,    busy_next;

   assign count_inc = (count_reg == CNT_MAX) ? count_reg : count_reg + CNT_ONE;

   always_comb begin
      state_next   = state_reg;
      count_next   = count_inc;
      press_next   = rise;
      // A fall seen in IDLE can only be the release of a button held through reset.
      release_next = fall && (state_reg != IDLE);
      short_next   = 1'b0;
      long_next    = 1'b0;
      double_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            count_next = '0;
            if (rise) begin
               state_next = PRESS1;
               count_next = CNT_ONE;
            end
         end
         PRESS1: begin
            if (fall) begin
               // The release sample is already the first low sample of the gap.
               if (CNT_ONE >= GAP_LIM) begin
                  short_next = 1'b1;
                  state_next = IDLE;
                  count_next = '0;
               end else begin
                  state_next = WAIT_GAP;
                  count_next = CNT_ONE;
               end
            end else if (count_inc >= LONG_LIM) begin
               long_next  = 1'b1;
               state_next = LONG_HELD;
               count_next = '0;
            end
         end
         LONG_HELD: begin
            if (fall) begin
               state_next = IDLE;
               count_next = '0;
            end
         end
         WAIT_GAP: begin
            if (rise) begin
               state_next = PRESS2;
               count_next = '0;
            end else if (count_inc >= GAP_LIM) begin
               short_next = 1'b1;
               state_next = IDLE;
               count_next = '0;
            end
         end
         PRESS2: begin
            if (fall) begin
               double_next = 1'b1;
               state_next  = IDLE;
               count_next  = '0;
            end
         end
         default: begin
            state_next = IDLE;
            count_next = '0;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         count_reg   <= '0;
         press_reg   <= 1'b0;
         release_reg <= 1'b0;
         short_reg   <= 1'b0;
         long_reg    <= 1'b0;
         double_reg  <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         press_reg   <= press_next;
         release_reg <= release_next;
         short_reg   <= short_next;
         long_reg    <= long_next;
         double_reg  <= double_next;
         busy_reg    <= busy_next;
      end
   end

   assign bus.press_pulse   = press_reg;
   assign bus.release_pulse = release_reg;
   assign bus.short_press   = short_reg;
   assign bus.long_press    = long_reg;
   assign bus.double_click  = double_reg;
   assign bus.busy          = busy_reg;
endmodule

// File: tb/tb_button_event_fsm.sv
// Directed and randomized button sequences checked against a timestamp-based
// behavioural model of press classification.
module tb_button_event_fsm;
   localparam int LONG = 16;
   localparam int GAP  = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   button_event_fsm_if bus ();

   button_event_fsm #(.LONG_CYCLES(LONG), .GAP_CYCLES(GAP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   string phase = "init";

   // Reference model: a press sequence is described by timestamps, not counters.
   int   m_n;
   logic m_prev;
   bit   m_active, m_released, m_long;
   int   m_presses, m_t_press, m_t_rel;

   // DUT pulse tallies per directed phase
   int c_press, c_rel, c_short, c_long, c_dbl;

   function automatic logic [5:0] obs();
      return {bus.press_pulse, bus.release_pulse, bus.short_press,
              bus.long_press, bus.double_click, bus.busy};
   endfunction

   task automatic check(input string tag, input logic [5:0] o, input logic [5:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b (press,rel,short,long,dbl,busy)", tag, o, e);
      end
   endtask

   task automatic model_reset();
      m_prev = 1'b1; m_active = 0; m_released = 0; m_long = 0;
      m_presses = 0; m_t_press = 0; m_t_rel = 0; m_n = 0;
   endtask

   task automatic model_step(input logic s, output logic [5:0] e);
      logic rise, fall;
      logic e_p, e_r, e_s, e_l, e_d;
      rise = s & ~m_prev;
      fall = ~s & m_prev;
      e_p = rise; e_r = 0; e_s = 0; e_l = 0; e_d = 0;
      if (!m_active) begin
         if (rise) begin
            m_active = 1; m_presses = 1; m_t_press = m_n; m_released = 0; m_long = 0;
         end
      end else begin
         if (fall) e_r = 1;
         if (m_long) begin
            if (fall) m_active = 0;
         end else if (m_presses == 1 && !m_released) begin
            if (fall) begin
               m_released = 1; m_t_rel = m_n;
               if (GAP == 1) begin e_s = 1; m_active = 0; end
            end else if (m_n - m_t_press + 1 == LONG) begin
               e_l = 1; m_long = 1;
            end
         end else if (m_presses == 1) begin
            if (rise) m_presses = 2;
            else if (m_n - m_t_rel + 1 == GAP) begin e_s = 1; m_active = 0; end
         end else begin
            if (fall) begin e_d = 1; m_active = 0; end
         end
      end
      e = {e_p, e_r, e_s, e_l, e_d, m_active};
      m_prev = s;
      m_n++;
   endtask

   task automatic step(input logic v);
      logic [5:0] e, o;
      @(negedge clk);
      bus.clean_in = v;
      @(posedge clk);
      #1;
      model_step(v, e);
      o = obs();
      check(phase, o, e);
      n_cmp++;
      assert ($countones(o[3:1]) <= 1) else begin
         n_bad++;
         $error("FAIL %s_onehot observed=%b expected=at most one class pulse", phase, o[3:1]);
      end
      c_press += int'(o[5]); c_rel += int'(o[4]); c_short += int'(o[3]);
      c_long  += int'(o[2]); c_dbl += int'(o[1]);
   endtask

   task automatic run(input logic v, input int len);
      for (int i = 0; i < len; i++) step(v);
      $display("[%0t] %s: level=%0d for %0d cycles", $time, phase, v, len);
   endtask

   task automatic clear_counts();
      c_press = 0; c_rel = 0; c_short = 0; c_long = 0; c_dbl = 0;
   endtask

   task automatic check_counts(input int p, input int r, input int s, input int l, input int d);
      n_cmp++;
      assert (c_press == p && c_rel == r && c_short == s && c_long == l && c_dbl == d) else begin
         n_bad++;
         $error("FAIL %s_counts observed=%0d/%0d/%0d/%0d/%0d expected=%0d/%0d/%0d/%0d/%0d",
                phase, c_press, c_rel, c_short, c_long, c_dbl, p, r, s, l, d);
      end
      clear_counts();
   endtask

   task automatic do_reset(input logic lvl);
      bus.clean_in = lvl;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check({phase, "_in_reset"}, obs(), 6'b0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      bus.clean_in = 1'b0;
      model_reset();
      clear_counts();
      phase = "reset";
      do_reset(1'b0);
      run(1'b0, 3);
      check_counts(0, 0, 0, 0, 0);

      phase = "t1_short";
      run(1'b1, 5); run(1'b0, 8); run(1'b0, 2);
      check_counts(1, 1, 1, 0, 0);

      phase = "t2_long";
      run(1'b1, 40); run(1'b0, 10);
      check_counts(1, 1, 0, 1, 0);

      phase = "t3_double";
      run(1'b1, 3); run(1'b0, 4); run(1'b1, 3); run(1'b0, 10);
      check_counts(2, 2, 0, 0, 1);

      phase = "t4a_gap_rise_wins";
      run(1'b1, 3); run(1'b0, 7); run(1'b1, 3); run(1'b0, 10);
      check_counts(2, 2, 0, 0, 1);

      phase = "t4b_gap_expired";
      run(1'b1, 3); run(1'b0, 8); run(1'b1, 3); run(1'b0, 10);
      check_counts(2, 2, 2, 0, 0);

      phase = "t5_held_through_reset";
      do_reset(1'b1);
      clear_counts();
      run(1'b1, 5); run(1'b0, 3);
      check_counts(0, 0, 0, 0, 0);
      run(1'b1, 3); run(1'b0, 10);
      check_counts(1, 1, 1, 0, 0);

      phase = "t6_reset_mid_press";
      run(1'b1, 10);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_clear", obs(), 6'b0);
      bus.clean_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      clear_counts();
      run(1'b0, 12);
      check_counts(0, 0, 0, 0, 0);

      phase = "random";
      for (int k = 0; k < 40; k++) begin
         run(1'b1, int'($urandom_range(1, LONG + 4)));
         run(1'b0, int'($urandom_range(1, GAP + 3)));
      end
      run(1'b0, GAP + 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/button_event_fsm.md
Name: button_event_fsm

Overview:
- Downstream consumer of the debounced button level.
- Converts the clean level into single-cycle event pulses for control logic: press, release, short press, long press and double click.
- Input is already synchronous to clk and glitch-free, so no synchroniser or filtering is done here.
- Event classification is driven by a state machine plus one shared cycle counter.

Parameters:
LONG_CYCLES, 16, consecutive high samples that qualify a long press (legal: >= 2)
GAP_CYCLES, 8, consecutive low samples after a short release before short_press is declared (legal: >= 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clean_in  input  1  debounced button level, synchronous to clk
press_pulse  output  1  one-cycle pulse on each accepted rising edge
release_pulse  output  1  one-cycle pulse on each accepted falling edge
short_press  output  1  one-cycle pulse, single short press classified
long_press  output  1  one-cycle pulse, press held LONG_CYCLES
double_click  output  1  one-cycle pulse, second press of a pair released
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, counter=0, all pulse outputs 0, busy 0, prev register = 1.
  - prev=1 means a button held through reset produces no event; it must first be released, then pressed again.
- Edges: rise = clean_in & ~prev; fall = ~clean_in & prev. prev <= clean_in every cycle.
- All outputs are registered: each pulse appears exactly one cycle after the sample that causes it, and lasts exactly one cycle.
- press_pulse/release_pulse fire on every rise/fall in every state except as noted under IDLE.
- Counter: width $clog2(max(LONG_CYCLES, GAP_CYCLES))+1, saturating, cleared on every state transition.
- States and transitions:
  - IDLE: rise -> PRESS1, counter=1. A fall in IDLE with no preceding rise (post-reset case) is ignored and produces no release_pulse.
  - PRESS1: while high, counter+1.
    - Counter reaching LONG_CYCLES -> pulse long_press, go to LONG_HELD.
    - Fall before that -> WAIT_GAP, counter=1.
  - LONG_HELD: stays until fall -> IDLE. No short_press or double_click is ever produced from a long press; long_press never repeats.
  - WAIT_GAP: while low, counter+1.
    - Rise -> PRESS2.
    - Counter reaching GAP_CYCLES with no rise -> pulse short_press, go to IDLE.
    - Rise on the same sample the gap would expire: rise wins, giving PRESS2 and no short_press.
  - PRESS2: fall -> pulse double_click, go to IDLE, regardless of hold length. No long_press from PRESS2.
- At most one of short_press/long_press/double_click is high in any cycle.
- Reset asserted mid-sequence: outputs drop to 0 asynchronously; the pending classification is discarded.

Decomposition:
- Shared package btn_pkg:
  - state enum (IDLE, PRESS1, LONG_HELD, WAIT_GAP, PRESS2)
  - event-code constants, for later reuse by an event-encoder/FIFO stage
- Sub-module btn_edge_det: prev register (reset value 1) producing rise/fall. Instantiated once.
- Parameter legality is checked at elaboration.

Test Plan:
1. Defaults. Hold clean_in high 5 cycles, then low 8 -> press_pulse 1 cycle after the rise, release_pulse 1 cycle after the fall, short_press single pulse 1 cycle after the 8th low sample; long_press/double_click stay 0.
2. Hold high 40 cycles -> long_press exactly once, 1 cycle after the 16th high sample; release -> release_pulse, busy drops, no short_press.
3. High 3, low 4, high 3, low -> two press_pulse and two release_pulse; double_click once, 1 cycle after the second fall; short_press never.
4. Gap boundary, two sub-cases:
   - High 3, low 7, rise on the 8th sample -> double_click path, no short_press.
   - High 3, low 8, then rise -> short_press, then a fresh PRESS1 with press_pulse.
5. Hold clean_in=1 through rst_n deassertion -> no press_pulse/release_pulse. Release, then press again -> normal press_pulse.
6. Assert rst_n mid-PRESS1 (counter=10) -> all outputs 0 immediately. Deassert with clean_in=0 -> state IDLE, busy 0, no events.
